// File: rtl/counter_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : counter_scheduler
// Purpose  : Walks a (step, limit, repeat) table, driving a wrap counter's
//            constants/reset and counting its clear pulses per entry.
// Revision : 1.0 - initial release
// ============================================================================
module counter_scheduler #(
    parameter int NUM_CFG = 4,
    parameter int CW      = 7,
    parameter int RW      = 4,
    localparam int IW     = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_idx,
    input  logic [CW-1:0] cfg_step,
    input  logic [CW-1:0] cfg_limit,
    input  logic [RW-1:0] cfg_reps,
    input  logic          start,
    input  logic          stop,
    input  logic          clr_in,
    output logic [CW-1:0] const1,
    output logic [CW-1:0] const2,
    output logic          cnt_reset,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [IW-1:0] cur_idx,
    output logic [RW-1:0] wrap_cnt
);

    localparam logic [IW-1:0] c_LAST_IDX = IW'(NUM_CFG - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_NEXT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        r_state;
    logic [CW:0]   r_gap;
    logic [CW-1:0] r_tbl_step  [NUM_CFG];
    logic [CW-1:0] r_tbl_limit [NUM_CFG];
    logic [RW-1:0] r_tbl_reps  [NUM_CFG];

    logic [RW-1:0] w_wrap_nxt;
    logic [RW-1:0] w_cur_reps;
    logic          w_abort;

    assign w_wrap_nxt = wrap_cnt + 1'b1;
    assign w_cur_reps = r_tbl_reps[cur_idx];
    assign w_abort    = stop && ((r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_NEXT));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_gap     <= '0;
            const1    <= '0;
            const2    <= '0;
            cnt_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cur_idx   <= '0;
            wrap_cnt  <= '0;
            for (int i = 0; i < NUM_CFG; i++) begin
                r_tbl_step[i]  <= '0;
                r_tbl_limit[i] <= '0;
                r_tbl_reps[i]  <= '0;
            end
        end else begin
            done <= 1'b0;
            if (w_abort) begin
                r_state   <= S_IDLE;
                busy      <= 1'b0;
                cnt_reset <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (cfg_we) begin
                            r_tbl_step[cfg_idx]  <= cfg_step;
                            r_tbl_limit[cfg_idx] <= cfg_limit;
                            r_tbl_reps[cfg_idx]  <= cfg_reps;
                        end
                        if (start) begin
                            r_state   <= S_LOAD;
                            cur_idx   <= '0;
                            err       <= 1'b0;
                            busy      <= 1'b1;
                            cnt_reset <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        const1   <= r_tbl_step[cur_idx];
                        const2   <= r_tbl_limit[cur_idx];
                        wrap_cnt <= '0;
                        r_gap    <= '0;
                        if (w_cur_reps == '0) begin
                            r_state   <= S_NEXT;
                            cnt_reset <= 1'b1;
                        end else begin
                            r_state   <= S_RUN;
                            cnt_reset <= 1'b0;
                        end
                    end
                    S_RUN: begin
                        // A clear in the same cycle as the timeout wins.
                        if (clr_in) begin
                            wrap_cnt <= w_wrap_nxt;
                            r_gap    <= '0;
                            if (w_wrap_nxt == w_cur_reps) begin
                                r_state   <= S_NEXT;
                                cnt_reset <= 1'b1;
                            end
                        end else if (r_gap == {1'b0, const2}) begin
                            err       <= 1'b1;
                            r_state   <= S_NEXT;
                            cnt_reset <= 1'b1;
                        end else begin
                            r_gap <= r_gap + 1'b1;
                        end
                    end
                    S_NEXT: begin
                        if (cur_idx == c_LAST_IDX) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            cur_idx <= cur_idx + 1'b1;
                            r_state <= S_LOAD;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        busy      <= 1'b0;
                        cnt_reset <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_counter_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_scheduler
// Purpose  : Directed self-checking bench for counter_scheduler with a
//            behavioural step/limit counter closing the clear loop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_scheduler;

    localparam int NUM_CFG = 4;
    localparam int CW      = 7;
    localparam int RW      = 4;
    localparam int IW      = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [CW-1:0] cfg_step;
    logic [CW-1:0] cfg_limit;
    logic [RW-1:0] cfg_reps;
    logic          start;
    logic          stop;
    logic          clr_in;
    logic [CW-1:0] const1;
    logic [CW-1:0] const2;
    logic          cnt_reset;
    logic          busy;
    logic          done;
    logic          err;
    logic [IW-1:0] cur_idx;
    logic [RW-1:0] wrap_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [CW-1:0] r_model_cnt;

    counter_scheduler #(.NUM_CFG(NUM_CFG), .CW(CW), .RW(RW)) u_dut (
        .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_step(cfg_step), .cfg_limit(cfg_limit), .cfg_reps(cfg_reps),
        .start(start), .stop(stop), .clr_in(clr_in),
        .const1(const1), .const2(const2), .cnt_reset(cnt_reset), .busy(busy),
        .done(done), .err(err), .cur_idx(cur_idx), .wrap_cnt(wrap_cnt)
    );

    always #5 clk = ~clk;

    // Wrap counter: clears when value equals limit, including while held in reset.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)                r_model_cnt <= '0;
        else if (cnt_reset)          r_model_cnt <= '0;
        else if (r_model_cnt == const2) r_model_cnt <= '0;
        else                         r_model_cnt <= r_model_cnt + const1;
    end
    assign clr_in = (r_model_cnt == const2);

    task automatic write_cfg(input int idx, input int st, input int lim, input int rep, input bit with_start);
        cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_step = CW'(st); cfg_limit = CW'(lim);
        cfg_reps = RW'(rep); start = with_start;
        @(negedge clk);
        cfg_we = 1'b0; start = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        int n;
        n_tests++;
        if ({const1, const2, cnt_reset, busy, done, err, cur_idx, wrap_cnt} !== {7'd0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0}) begin
            n_fail++; $display("FAIL reset_por: got %h expected %h",
                {const1, const2, cnt_reset, busy, done, err, cur_idx, wrap_cnt}, {7'd0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0});
        end
        reset_n = 1'b1;
        @(negedge clk);
        write_cfg(0, 1, 3, 2, 1'b0);
        do_start();
        repeat (2) @(negedge clk);
        n_tests++;
        if (busy !== 1'b1 || cnt_reset !== 1'b0) begin
            n_fail++; $display("FAIL reset_prerun: got busy=%b cnt_reset=%b expected busy=1 cnt_reset=0", busy, cnt_reset);
        end
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({const1, const2, cnt_reset, busy, done, err, cur_idx, wrap_cnt} !== {7'd0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0}) begin
            n_fail++; $display("FAIL reset_async: got %h expected %h",
                {const1, const2, cnt_reset, busy, done, err, cur_idx, wrap_cnt}, {7'd0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0});
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_start();
        wait_done(20, n);
        n_tests++;
        if (n !== 8) begin n_fail++; $display("FAIL reset_zero_table_done: got T+%0d expected T+9", n + 1); end
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_zero_table_err: got %b expected 0", err); end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_after_done: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_single();
        int n;
        logic exp_clr;
        logic [RW-1:0] exp_wrap;
        write_cfg(0, 1, 3, 2, 1'b0);
        do_start();
        n_tests++;
        if (busy !== 1'b1 || cnt_reset !== 1'b1 || cur_idx !== 2'd0) begin
            n_fail++; $display("FAIL single_load: got busy=%b cnt_reset=%b idx=%0d expected 1 1 0", busy, cnt_reset, cur_idx);
        end
        @(negedge clk);
        n_tests++;
        if (const1 !== 7'd1 || const2 !== 7'd3 || cnt_reset !== 1'b0) begin
            n_fail++; $display("FAIL single_consts: got %0d/%0d rst=%b expected 1/3 rst=0", const1, const2, cnt_reset);
        end
        for (int j = 0; j < 8; j++) begin
            if (j > 0) @(negedge clk);
            exp_clr  = (j == 3) || (j == 7);
            exp_wrap = (j >= 4) ? 4'd1 : 4'd0;
            n_tests++;
            if (clr_in !== exp_clr || wrap_cnt !== exp_wrap) begin
                n_fail++; $display("FAIL single_run%0d: got clr=%b wrap=%0d expected clr=%b wrap=%0d", j, clr_in, wrap_cnt, exp_clr, exp_wrap);
            end
        end
        @(negedge clk);
        n_tests++;
        if (wrap_cnt !== 4'd2 || cnt_reset !== 1'b1) begin
            n_fail++; $display("FAIL single_next: got wrap=%0d rst=%b expected 2 1", wrap_cnt, cnt_reset);
        end
        wait_done(20, n);
        n_tests++;
        if (n !== 7 || err !== 1'b0) begin
            n_fail++; $display("FAIL single_done: got %0d cycles err=%b expected 7 cycles err=0", n, err);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL single_done_pulse: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_two_entries();
        logic exp_clr;
        logic [IW-1:0] exp_idx;
        logic [CW-1:0] exp_c1;
        write_cfg(0, 3, 9, 1, 1'b0);
        write_cfg(1, 2, 4, 3, 1'b0);
        do_start();
        for (int i = 2; i <= 22; i++) begin
            @(negedge clk);
            if (i <= 16) begin
                exp_clr = (i == 5) || (i == 10) || (i == 13) || (i == 16);
                n_tests++;
                if (clr_in !== exp_clr) begin
                    n_fail++; $display("FAIL two_clr_T%0d: got %b expected %b", i, clr_in, exp_clr);
                end
            end
            exp_idx = (i <= 6) ? 2'd0 : (i <= 17) ? 2'd1 : (i <= 19) ? 2'd2 : 2'd3;
            exp_c1  = (i <= 7) ? 7'd3 : (i <= 18) ? 7'd2 : 7'd0;
            n_tests++;
            if (cur_idx !== exp_idx || const1 !== exp_c1 || done !== (i == 22)) begin
                n_fail++; $display("FAIL two_T%0d: got idx=%0d c1=%0d done=%b expected idx=%0d c1=%0d done=%b",
                    i, cur_idx, const1, done, exp_idx, exp_c1, (i == 22));
            end
            if (i == 17) begin
                n_tests++;
                if (wrap_cnt !== 4'd3) begin n_fail++; $display("FAIL two_wrap: got %0d expected 3", wrap_cnt); end
            end
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL two_idle: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_timeout();
        write_cfg(0, 2, 5, 1, 1'b0);
        write_cfg(1, 2, 4, 0, 1'b0);
        do_start();
        for (int i = 2; i <= 15; i++) begin
            @(negedge clk);
            if (i <= 7) begin
                n_tests++;
                if (clr_in !== 1'b0 || cnt_reset !== 1'b0 || err !== 1'b0) begin
                    n_fail++; $display("FAIL timeout_run_T%0d: got clr=%b rst=%b err=%b expected 0 0 0", i, clr_in, cnt_reset, err);
                end
            end else begin
                n_tests++;
                if (err !== 1'b1 || done !== (i == 15)) begin
                    n_fail++; $display("FAIL timeout_T%0d: got err=%b done=%b expected err=1 done=%b", i, err, done, (i == 15));
                end
            end
            if (i == 8) begin
                n_tests++;
                if (cnt_reset !== 1'b1) begin n_fail++; $display("FAIL timeout_next_rst: got %b expected 1", cnt_reset); end
            end
        end
        @(negedge clk);
        n_tests++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL timeout_sticky: got err=%b busy=%b expected 1 0", err, busy);
        end
        do_start();
        n_tests++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL timeout_err_clear: got err=%b busy=%b expected 0 1", err, busy);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || cnt_reset !== 1'b1) begin
            n_fail++; $display("FAIL timeout_stop_load: got busy=%b rst=%b expected 0 1", busy, cnt_reset);
        end
    endtask

    task automatic test_limit_zero();
        logic [RW-1:0] exp_wrap;
        logic exp_rst;
        write_cfg(1, 1, 0, 2, 1'b0);
        write_cfg(0, 1, 0, 3, 1'b1);
        for (int i = 2; i <= 14; i++) begin
            @(negedge clk);
            if (i <= 9) begin
                case (i)
                    2: exp_wrap = 4'd0; 3: exp_wrap = 4'd1; 4: exp_wrap = 4'd2;
                    5, 6: exp_wrap = 4'd3; 7: exp_wrap = 4'd0; 8: exp_wrap = 4'd1;
                    default: exp_wrap = 4'd2;
                endcase
                exp_rst = !((i >= 2 && i <= 4) || i == 7 || i == 8);
                n_tests++;
                if (wrap_cnt !== exp_wrap || cnt_reset !== exp_rst || clr_in !== 1'b1) begin
                    n_fail++; $display("FAIL lim0_T%0d: got wrap=%0d rst=%b clr=%b expected wrap=%0d rst=%b clr=1",
                        i, wrap_cnt, cnt_reset, clr_in, exp_wrap, exp_rst);
                end
            end
            if (i == 6) begin
                n_tests++;
                if (cur_idx !== 2'd1) begin n_fail++; $display("FAIL lim0_load_idx: got %0d expected 1", cur_idx); end
            end
            n_tests++;
            if (done !== (i == 14)) begin
                n_fail++; $display("FAIL lim0_done_T%0d: got %b expected %b", i, done, (i == 14));
            end
        end
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL lim0_err: got %b expected 0", err); end
        @(negedge clk);
    endtask

    task automatic test_stop_busy();
        int n_done;
        write_cfg(0, 1, 3, 2, 1'b0);
        write_cfg(1, 0, 0, 0, 1'b0);
        do_start();
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_step = 7'd5; cfg_limit = 7'd10; cfg_reps = 4'd1; start = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0; start = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || cnt_reset !== 1'b0 || cur_idx !== 2'd0) begin
            n_fail++; $display("FAIL busy_start_ignored: got busy=%b rst=%b idx=%0d expected 1 0 0", busy, cnt_reset, cur_idx);
        end
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || cnt_reset !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL stop_run: got busy=%b rst=%b done=%b expected 0 1 0", busy, cnt_reset, done);
        end
        n_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) n_done++;
        end
        n_tests++;
        if (n_done !== 0) begin n_fail++; $display("FAIL stop_stays_idle: got %0d active cycles expected 0", n_done); end
        do_start();
        @(negedge clk);
        n_tests++;
        if (const1 !== 7'd1 || const2 !== 7'd3) begin
            n_fail++; $display("FAIL busy_write_ignored: got %0d/%0d expected 1/3", const1, const2);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_final: got busy=%b expected 0", busy); end
    endtask

    initial begin
        reset_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_step = '0; cfg_limit = '0;
        cfg_reps = '0; start = 1'b0; stop = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_two_entries();
        test_timeout();
        test_limit_zero();
        test_stop_busy();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1);
    end

endmodule
`default_nettype wire
